counter_sweep_ctrl: RTL and testbench
=====================================

Name: counter_sweep_ctrl

Overview:
Control stage directly upstream of the loadable up/down counter. It drives that counter's load_en, counter_in and up_down, and watches its counter_out, so the counter produces a triangle sweep between programmable bounds. Supports continuous and single-sweep modes, a start/stop handshake, and bound error reporting. Because the counter advances every cycle it is not loading, this block freezes the counter when idle by loading the counter's own value back into it.

Parameters:
CNT_WIDTH, 3, width of the counter, the bounds and cnt_val; must match the counter instance.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a sweep; honoured only in IDLE
stop  in  1  abort the sweep; takes priority over start
mode_cont  in  1  1 = continuous triangle, 0 = one up-down sweep then stop; sampled with start
lo_bound  in  CNT_WIDTH  lower sweep limit; sampled with start
hi_bound  in  CNT_WIDTH  upper sweep limit; sampled with start
cnt_val  in  CNT_WIDTH  counter_out of the downstream counter
load_en  out  1  to counter load_en (combinational)
counter_in  out  CNT_WIDTH  to counter counter_in (combinational)
up_down  out  1  to counter up_down (combinational)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on completion of a single sweep (registered)
dir_flip  out  1  one-cycle pulse the cycle after each turn (registered)
bound_err  out  1  one-cycle pulse when start is rejected (registered)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; lo_q=hi_q=mode_q=0; done=dir_flip=bound_err=0.
- State machine: IDLE, LOAD, UP, DOWN. Outputs are decoded combinationally from the state and cnt_val. The counter is registered, so there is no combinational loop.
- IDLE: load_en=1, counter_in=cnt_val, up_down=1, so the counter holds its value.
  - start=1, stop=0, lo_bound<hi_bound: capture lo_q, hi_q and mode_q, then go to LOAD.
  - start=1 with lo_bound>=hi_bound: stay in IDLE; bound_err=1 on the next cycle; captured registers unchanged.
- LOAD: load_en=1, counter_in=lo_q, then go to UP. The counter equals lo_q one edge later.
- UP: load_en=0.
  - cnt_val<hi_q: up_down=1; stay in UP.
  - cnt_val>=hi_q: up_down=0; go to DOWN; dir_flip=1 next cycle.
- DOWN: load_en=0.
  - cnt_val>lo_q: up_down=0; stay in DOWN.
  - cnt_val<=lo_q and mode_q=1: up_down=1; go to UP; dir_flip=1 next cycle.
  - cnt_val<=lo_q and mode_q=0: load_en=1, counter_in=lo_q; go to IDLE; done=1 next cycle.
- The >= and <= comparisons keep the sweep bounded if the counter value is disturbed. No counter wrap-around can occur while the counter stays in range.
- Continuous sequence: lo, lo+1 … hi, hi-1 … lo, lo+1 …; period 2*(hi-lo) cycles.
- stop=1 in LOAD, UP or DOWN: that same cycle outputs load_en=1, counter_in=cnt_val (freeze); go to IDLE. No done pulse; dir_flip is suppressed.
- stop and start together in IDLE: start is ignored.
- start while busy: ignored. Bound inputs changed while busy: ignored until the next start.
- Reset mid-sweep: return to IDLE immediately. The counter shares reset_n and returns to 0.
- All comparisons are unsigned, CNT_WIDTH bits wide. Full range lo=0, hi=2^CNT_WIDTH-1 is legal.

Test Plan:
- Continuous, lo=2, hi=5, mode_cont=1, start pulse at cycle 0 -> busy from cycle 1; cnt_val from cycle 2: 2,3,4,5,4,3,2,3,4…; dir_flip pulses the cycle after cnt_val=5 and the cycle after cnt_val=2 (DOWN).
- Single, lo=1, hi=3, mode_cont=0 -> cnt_val 1,2,3,2,1, then held at 1; done high one cycle; busy low; cnt_val stays 1 for 10+ cycles.
- Bound errors: lo=4, hi=4 start -> bound_err one pulse, busy stays 0, cnt_val unchanged; repeat with lo=6, hi=2 -> same.
- Stop at cnt_val=4 going up (lo=0, hi=7) -> cnt_val frozen at 4; busy 0 next cycle; no done; a later start reloads lo.
- Full range lo=0, hi=7 continuous -> 0…7…0 without wrap; start and stop together in IDLE -> no sweep.
- Async reset_n low mid-DOWN -> state IDLE, busy=0, all pulses 0 immediately; after release, cnt_val held at 0.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// counter_sweep_ctrl : steers a loadable up/down counter through a bounded
//                      triangle sweep (continuous or single), with start/stop.
// Rev 1.0
// ============================================================================
module counter_sweep_ctrl #(
   parameter int CNT_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 mode_cont,
   input  logic [CNT_WIDTH-1:0] lo_bound,
   input  logic [CNT_WIDTH-1:0] hi_bound,
   input  logic [CNT_WIDTH-1:0] cnt_val,
   output logic                 load_en,
   output logic [CNT_WIDTH-1:0] counter_in,
   output logic                 up_down,
   output logic                 busy,
   output logic                 done,
   output logic                 dir_flip,
   output logic                 bound_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_UP   = 2'd2,
      ST_DOWN = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CNT_WIDTH-1:0] r_lo;
   logic [CNT_WIDTH-1:0] r_hi;
   logic                 r_mode;
   logic                 r_done;
   logic                 r_flip;
   logic                 r_berr;
   logic                 w_capture;
   logic                 w_done;
   logic                 w_flip;
   logic                 w_berr;

   // Loading cnt_val back into the counter is how it is held still.
   always_comb begin
      w_next     = r_state;
      load_en    = 1'b0;
      counter_in = cnt_val;
      up_down    = 1'b1;
      w_capture  = 1'b0;
      w_done     = 1'b0;
      w_flip     = 1'b0;
      w_berr     = 1'b0;
      if (r_state != ST_IDLE && stop) begin
         load_en = 1'b1;
         w_next  = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               load_en = 1'b1;
               if (start && !stop) begin
                  if (lo_bound < hi_bound) begin
                     w_capture = 1'b1;
                     w_next    = ST_LOAD;
                  end else begin
                     w_berr = 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               load_en    = 1'b1;
               counter_in = r_lo;
               w_next     = ST_UP;
            end
            ST_UP: begin
               if (cnt_val >= r_hi) begin
                  up_down = 1'b0;
                  w_flip  = 1'b1;
                  w_next  = ST_DOWN;
               end
            end
            ST_DOWN: begin
               up_down = 1'b0;
               if (cnt_val <= r_lo) begin
                  if (r_mode) begin
                     up_down = 1'b1;
                     w_flip  = 1'b1;
                     w_next  = ST_UP;
                  end else begin
                     load_en    = 1'b1;
                     counter_in = r_lo;
                     w_done     = 1'b1;
                     w_next     = ST_IDLE;
                  end
               end
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_lo    <= '0;
         r_hi    <= '0;
         r_mode  <= 1'b0;
         r_done  <= 1'b0;
         r_flip  <= 1'b0;
         r_berr  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_done;
         r_flip  <= w_flip;
         r_berr  <= w_berr;
         if (w_capture) begin
            r_lo   <= lo_bound;
            r_hi   <= hi_bound;
            r_mode <= mode_cont;
         end
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign dir_flip  = r_flip;
   assign bound_err = r_berr;

endmodule
`default_nettype wire

// File: tb/tb_counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// tb_counter_sweep_ctrl : sweep controller closed around a counter model,
//                         checked against a closed-form triangle reference.
// Rev 1.0
// ============================================================================
module tb_counter_sweep_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode_cont = 1'b0;
   logic [2:0] lo_bound = '0;
   logic [2:0] hi_bound = '0;
   logic [2:0] cnt;
   logic       load_en;
   logic [2:0] counter_in;
   logic       up_down;
   logic       busy;
   logic       done;
   logic       dir_flip;
   logic       bound_err;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   counter_sweep_ctrl #(.CNT_WIDTH(3)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .stop       (stop),
      .mode_cont  (mode_cont),
      .lo_bound   (lo_bound),
      .hi_bound   (hi_bound),
      .cnt_val    (cnt),
      .load_en    (load_en),
      .counter_in (counter_in),
      .up_down    (up_down),
      .busy       (busy),
      .done       (done),
      .dir_flip   (dir_flip),
      .bound_err  (bound_err)
   );

   // Downstream loadable up/down counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     cnt <= '0;
      else if (load_en) cnt <= counter_in;
      else if (up_down) cnt <= cnt + 3'd1;
      else              cnt <= cnt - 3'd1;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int tri_val(input int k, input int lo, input int hi);
      int d;
      int r;
      d = hi - lo;
      r = k % (2 * d);
      return lo + ((r <= d) ? r : 2 * d - r);
   endfunction

   // Reference: k counts cycles since the counter reached lo (-1 = load cycle)
   int m_busy, m_k, m_lo, m_hi, m_mode, m_cnt, m_done, m_flip, m_berr;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy <= 0; m_k <= 0; m_lo <= 0; m_hi <= 0; m_mode <= 0;
         m_cnt <= 0; m_done <= 0; m_flip <= 0; m_berr <= 0;
      end else begin
         m_done <= 0; m_flip <= 0; m_berr <= 0;
         if (m_busy == 0) begin
            if (start && !stop) begin
               if (int'(lo_bound) < int'(hi_bound)) begin
                  m_busy <= 1; m_k <= -1;
                  m_lo <= int'(lo_bound); m_hi <= int'(hi_bound); m_mode <= int'(mode_cont);
               end else begin
                  m_berr <= 1;
               end
            end
         end else if (stop) begin
            m_busy <= 0;
         end else if (m_k >= 0 && m_mode == 0 && m_k == 2 * (m_hi - m_lo)) begin
            m_busy <= 0;
            m_done <= 1;
         end else begin
            m_k   <= m_k + 1;
            m_cnt <= tri_val(m_k + 1, m_lo, m_hi);
            if (m_k >= 0 && ((m_k % (2 * (m_hi - m_lo))) == (m_hi - m_lo) ||
                             (m_k > 0 && (m_k % (2 * (m_hi - m_lo))) == 0)))
               m_flip <= 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ref_cnt", int'(cnt), m_cnt);
         chk("ref_busy", int'(busy), m_busy);
         chk("ref_done", int'(done), m_done);
         chk("ref_dir_flip", int'(dir_flip), m_flip);
         chk("ref_bound_err", int'(bound_err), m_berr);
         if (m_busy == 0) begin
            chk("ref_idle_load_en", int'(load_en), 1);
            chk("ref_idle_counter_in", int'(counter_in), m_cnt);
         end
      end
   end

   typedef struct {
      logic       stp;
      logic [2:0] lo;
      logic [2:0] hi;
      logic       exp_busy;
      logic       exp_berr;
   } vec_t;

   vec_t vecs[7];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      start = 1'b0;
      stop  = 1'b1;
      cyc();
      stop  = 1'b0;
      cyc();
   endtask

   task automatic kick(input logic [2:0] lo, input logic [2:0] hi, input logic md);
      lo_bound  = lo;
      hi_bound  = hi;
      mode_cont = md;
      start     = 1'b1;
      cyc();
      start     = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_seq[9];
      int exp_flp[9];
      int sgl[5];
      int ndone;

      vecs[0] = '{1'b0, 3'd4, 3'd4, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 3'd6, 3'd2, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 3'd2, 3'd5, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 3'd2, 3'd5, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 3'd0, 3'd7, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 3'd7, 3'd0, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 3'd4, 3'd4, 1'b0, 1'b0};

      #2 reset_n = 1'b0;
      #20 reset_n = 1'b1;
      cyc();
      chk_en = 1'b1;

      chk("reset_busy", int'(busy), 0);
      chk("reset_cnt", int'(cnt), 0);
      chk("reset_pulses", int'({done, dir_flip, bound_err}), 0);

      // Start acceptance / rejection, every sweep aborted in LOAD so cnt stays 0
      for (int i = 0; i < 7; i++) begin
         stop = vecs[i].stp;
         kick(vecs[i].lo, vecs[i].hi, 1'b1);
         stop = 1'b0;
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_bound_err", i), int'(bound_err), int'(vecs[i].exp_berr));
         chk($sformatf("vec%0d_cnt", i), int'(cnt), 0);
         stop = 1'b1;
         cyc();
         stop = 1'b0;
         chk($sformatf("vec%0d_berr_once", i), int'(bound_err), 0);
         chk($sformatf("vec%0d_idle", i), int'(busy), 0);
         chk($sformatf("vec%0d_cnt_hold", i), int'(cnt), 0);
         cyc();
      end

      // Continuous 2..5
      exp_seq = '{2, 3, 4, 5, 4, 3, 2, 3, 4};
      exp_flp = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
      kick(3'd2, 3'd5, 1'b1);
      chk("cont_busy_c1", int'(busy), 1);
      cyc();
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("cont_cnt%0d", i), int'(cnt), exp_seq[i]);
         chk($sformatf("cont_flip%0d", i), int'(dir_flip), exp_flp[i]);
         cyc();
      end
      go_idle();

      // Single 1..3
      sgl = '{1, 2, 3, 2, 1};
      ndone = 0;
      kick(3'd1, 3'd3, 1'b0);
      cyc();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("single_cnt%0d", i), int'(cnt), (i < 5) ? sgl[i] : 1);
         chk($sformatf("single_busy%0d", i), int'(busy), (i < 5) ? 1 : 0);
         chk($sformatf("single_done%0d", i), int'(done), (i == 5) ? 1 : 0);
         if (done) ndone++;
         cyc();
      end
      chk("single_done_count", ndone, 1);

      // Stop while counting up at 4
      kick(3'd0, 3'd7, 1'b1);
      for (int i = 0; i < 5; i++) cyc();
      chk("stop_pre_cnt", int'(cnt), 4);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("stop_busy", int'(busy), 0);
      chk("stop_no_done", int'(done), 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stop_frozen%0d", i), int'(cnt), 4);
         cyc();
      end
      kick(3'd3, 3'd6, 1'b1);
      cyc();
      chk("restart_reload_lo", int'(cnt), 3);
      go_idle();

      // Full range, no wrap
      kick(3'd0, 3'd7, 1'b1);
      cyc();
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("full_cnt%0d", k), int'(cnt), (k % 14 <= 7) ? k % 14 : 14 - k % 14);
         cyc();
      end
      go_idle();

      // Async reset mid-DOWN
      kick(3'd2, 3'd6, 1'b1);
      for (int i = 0; i < 6; i++) cyc();
      chk("rst_pre_cnt", int'(cnt), 5);
      chk("rst_pre_flip", int'(dir_flip), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_pulses", int'({done, dir_flip, bound_err}), 0);
      chk("rst_cnt", int'(cnt), 0);
      #3 reset_n = 1'b1;
      cyc();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rst_hold%0d", i), int'(cnt), 0);
         chk($sformatf("rst_idle%0d", i), int'(busy), 0);
         cyc();
      end

      // Randomized traffic, checked by the reference on every cycle
      for (int i = 0; i < 2500; i++) begin
         start     = ($urandom_range(0, 7) == 0);
         stop      = ($urandom_range(0, 22) == 0);
         mode_cont = 1'($urandom_range(0, 1));
         lo_bound  = 3'($urandom_range(0, 7));
         hi_bound  = 3'($urandom_range(0, 7));
         cyc();
      end
      go_idle();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
